project: RTL and testbench

PROJECT -- requirements
Module: project

---
 rtl/project.sv | 177 +++++++++++++++++
 tb/tb_project.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/project.sv
// Cartesian (X,Y,Z) to cylindrical (R,theta,Z) converter.
// Iterative CORDIC in vectoring mode: one capture edge, eight micro-rotation
// edges, one result edge, 9 clocks of latency per sample.
// Optional feature macro: PROJECT_GAIN_COMP_EN -- when defined, R is scaled
// by 155/256 to remove the CORDIC gain; otherwise R is the raw CORDIC x.
module project (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  input  logic [7:0] z_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] z_out
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              r_state, w_next;
  logic                w_load, w_step, w_fin;
  logic signed [11:0]  r_x, r_y;
  logic [15:0]         r_z;
  logic [2:0]          r_cnt;
  logic [3:0]          r_sh;
  logic [7:0]          r_zin;
  logic                r_zero;

  // Rounded arithmetic right shift; rounding keeps the eight truncation
  // errors from piling up in one direction.
  function automatic logic signed [11:0] f_rsh(input logic signed [11:0] v,
                                               input logic [2:0] i);
    logic signed [12:0] t;
    logic signed [12:0] s;
    t = {v[11], v};
    if (i != 3'd0) t = t + (13'sd1 <<< (i - 3'd1));
    s = t >>> i;
    return s[11:0];
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: a conversion always runs to completion once accepted
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (ena) w_next = S_RUN;
      S_RUN:   if (r_cnt == 3'd7) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs: capture, iterate, publish
  always_comb begin
    w_load = (r_state == S_IDLE) && ena;
    w_step = (r_state == S_RUN);
    w_fin  = (r_state == S_DONE);
  end

  // Pre-rotation into the right half-plane plus input normalisation.
  // Small vectors are shifted up so the 12-bit datapath keeps angular
  // resolution; the shift is undone when R is formed.
  logic signed [11:0] w_xs, w_ys, w_px, w_py;
  logic [15:0]        w_z0;
  logic [7:0]         w_ax, w_ay, w_m;
  logic [3:0]         w_sh;

  // Quadrant fold and shift selection for the capture edge
  always_comb begin
    w_xs = $signed({{4{ui_in[7]}}, ui_in});
    w_ys = $signed({{4{uio_in[7]}}, uio_in});
    w_px = w_xs;
    w_py = w_ys;
    w_z0 = 16'h0000;
    if (w_xs[11]) begin
      if (!w_ys[11]) begin
        w_px = w_ys;  w_py = -w_xs; w_z0 = 16'h4000;   // rotate -90, preset +90
      end else begin
        w_px = -w_ys; w_py = w_xs;  w_z0 = 16'hC000;   // rotate +90, preset -90
      end
    end
    w_ax = ui_in[7]  ? (~ui_in  + 8'd1) : ui_in;
    w_ay = uio_in[7] ? (~uio_in + 8'd1) : uio_in;
    w_m  = (w_ax > w_ay) ? w_ax : w_ay;
    // keep max(|X|,|Y|) << sh <= 512 so x never exceeds ~1200
    casez (w_m)
      8'b1???????, 8'b01??????: w_sh = 4'd2;
      8'b001?????:              w_sh = 4'd3;
      8'b0001????:              w_sh = 4'd4;
      8'b00001???:              w_sh = 4'd5;
      8'b000001??:              w_sh = 4'd6;
      8'b0000001?:              w_sh = 4'd7;
      default:                  w_sh = 4'd8;
    endcase
  end

  // atan(2^-i) in units of 65536 per turn
  logic [15:0] w_atan;
  always_comb begin
    case (r_cnt)
      3'd0:    w_atan = 16'd8192;
      3'd1:    w_atan = 16'd4836;
      3'd2:    w_atan = 16'd2555;
      3'd3:    w_atan = 16'd1297;
      3'd4:    w_atan = 16'd651;
      3'd5:    w_atan = 16'd326;
      3'd6:    w_atan = 16'd163;
      default: w_atan = 16'd81;
    endcase
  end

  logic signed [11:0] w_xsh, w_ysh;
  assign w_xsh = f_rsh(r_x, r_cnt);
  assign w_ysh = f_rsh(r_y, r_cnt);

  // Iteration datapath: capture on E0, one micro-rotation per RUN edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0; r_y <= '0; r_z <= '0; r_cnt <= '0;
      r_sh <= '0; r_zin <= '0; r_zero <= 1'b0;
    end else if (w_load) begin
      r_x    <= w_px <<< w_sh;
      r_y    <= w_py <<< w_sh;
      r_z    <= w_z0;
      r_cnt  <= 3'd0;
      r_sh   <= w_sh;
      r_zin  <= z_in;
      r_zero <= (ui_in == 8'd0) && (uio_in == 8'd0);
    end else if (w_step) begin
      if (!r_y[11]) begin
        r_x <= r_x + w_ysh; r_y <= r_y - w_xsh; r_z <= r_z + w_atan;
      end else begin
        r_x <= r_x - w_ysh; r_y <= r_y + w_xsh; r_z <= r_z - w_atan;
      end
      r_cnt <= r_cnt + 3'd1;
    end
  end

  // Magnitude: undo the normalisation shift, optionally remove CORDIC gain
  logic [20:0] w_rq;
  logic [7:0]  w_r;
  logic [15:0] w_zr;
  always_comb begin
`ifdef PROJECT_GAIN_COMP_EN
    w_rq = (21'(r_x[10:0]) * 21'd155 + (21'd1 << (r_sh + 4'd7)))
           >> ({1'b0, r_sh} + 5'd8);
`else
    w_rq = (21'(r_x[10:0]) + (21'd1 << (r_sh - 4'd1))) >> r_sh;
`endif
    w_r  = (|w_rq[20:8]) ? 8'hFF : w_rq[7:0];
    w_zr = r_z + 16'd128;
  end

  // Result registers: all three outputs change together on the DONE edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uo_out <= '0; uio_out <= '0; z_out <= '0;
    end else if (w_fin) begin
      uo_out  <= w_r;
      uio_out <= r_zero ? 8'd0 : w_zr[15:8];
      z_out   <= r_zin;
    end
  end

  // uio pins drive theta from the first edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) uio_oe <= 8'h00;
    else        uio_oe <= 8'hFF;
  end

endmodule

// File: tb/tb_project.sv
// Scoreboard bench for project: stimulus pushes expected cylindrical
// results computed with real arithmetic; a negedge monitor compares on the
// due cycle and checks that outputs hold in between.
module tb_project;

  logic       clk, rst_n, ena;
  logic [7:0] ui_in, uio_in, z_in;
  logic [7:0] uo_out, uio_out, uio_oe, z_out;

  project dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .ui_in(ui_in), .uio_in(uio_in), .z_in(z_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe), .z_out(z_out)
  );

  typedef struct {
    int     r;
    int     th;
    int     z;
    bit     exact;
    longint due;
  } exp_t;

  exp_t   sb[$];
  exp_t   last_e, zero_e;
  logic [7:0] oe_exp;
  longint cyc = 0;
  int     n_vec = 0;
  int     n_bad = 0;

  localparam real PI = 3.14159265358979;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y,
                                 input logic [7:0] z);
    exp_t e;
    real xr, yr, mag, r, t, g;
    xr = $itor($signed(x));
    yr = $itor($signed(y));
    g  = 1.0;
    for (int i = 0; i < 8; i++) g = g * $sqrt(1.0 + 1.0 / (4.0 ** i));
    mag = $sqrt(xr * xr + yr * yr);
`ifdef PROJECT_GAIN_COMP_EN
    r = mag;
`else
    r = mag * g;
`endif
    e.r     = (r >= 254.5) ? 255 : $rtoi(r + 0.5);
    e.z     = int'(z);
    e.exact = (x == 8'd0) && (y == 8'd0);
    if (e.exact) e.th = 0;
    else begin
      t = $atan2(yr, xr) * 128.0 / PI;
      if (t < 0.0) t = t + 256.0;
      e.th = $rtoi(t + 0.5) % 256;
    end
    e.due = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input exp_t e);
    int   dr;
    logic [7:0] dt;
    dr = int'(uo_out) - e.r;
    dt = uio_out - 8'(e.th);
    n_vec++;
    if (e.exact ? (dr != 0) : (dr > 1 || dr < -1)) begin
      n_bad++;
      $display("FAIL %s R got %0d want %0d", nm, uo_out, e.r);
    end
    n_vec++;
    if (e.exact ? (dt != 8'd0) : !(dt == 8'd0 || dt == 8'd1 || dt == 8'd255)) begin
      n_bad++;
      $display("FAIL %s theta got %0d want %0d", nm, uio_out, e.th);
    end
    n_vec++;
    if (int'(z_out) != e.z) begin
      n_bad++;
      $display("FAIL %s z got %0d want %0d", nm, z_out, e.z);
    end
  endtask

  // Monitor: result on its due cycle, held values otherwise
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("result", e);
      last_e = e;
    end else begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        n_vec++; n_bad++;
        $display("FAIL missed result due %0d now %0d", sb[0].due, cyc);
        void'(sb.pop_front());
      end
      chk("hold", last_e);
    end
    n_vec++;
    if (uio_oe !== oe_exp) begin
      n_bad++;
      $display("FAIL uio_oe got %h want %h", uio_oe, oe_exp);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      ena = 1'b0;
    end
  endtask

  // One sample; garbage on the inputs during RUN/DONE; optional reset abort
  task automatic send(input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] z, input int abort_at);
    exp_t e;
    @(negedge clk); #1;
    ena = 1'b1; ui_in = x; uio_in = y; z_in = z;
    @(posedge clk); #1;
    e = model(x, y, z);
    e.due = cyc + 9;
    sb.push_back(e);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk); #1;
      ena = 1'($urandom); ui_in = 8'($urandom); uio_in = 8'($urandom);
      z_in = 8'($urandom);
      if (k == abort_at) begin
        #1;
        rst_n = 1'b0; ena = 1'b0;
        sb.delete();
        last_e = zero_e; oe_exp = 8'h00;
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        oe_exp = 8'hFF;
        break;
      end
    end
  endtask

  initial begin
    zero_e = '{r: 0, th: 0, z: 0, exact: 1'b1, due: 0};
    last_e = zero_e;
    oe_exp = 8'h00;
    rst_n = 1'b0; ena = 1'b0; ui_in = '0; uio_in = '0; z_in = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    oe_exp = 8'hFF;
    idle(6);                                   // ena low: outputs stay 0

    send(8'd10,  8'd10,  8'd5,  0);
    send(8'hF1,  8'd20,  8'd8,  0);
    send(8'd30,  8'hE7,  8'd12, 0);
    send(8'd0,   8'd0,   8'd10, 0);
    send(8'h80,  8'd0,   8'd33, 0);
    send(8'h80,  8'h80,  8'd1,  0);            // largest magnitude
    send(8'd127, 8'd127, 8'd255, 0);
    send(8'd1,   8'd0,   8'd2,  0);
    send(8'd0,   8'hFF,  8'd3,  0);
    send(8'hFF,  8'd0,   8'd4,  0);
    send(8'hFF,  8'hFF,  8'd6,  0);
    send(8'd0,   8'd127, 8'd7,  0);

    send(8'd50,  8'd60,  8'd99, 4);            // reset pulse mid-conversion
    idle(12);                                  // nothing stale may appear
    send(8'd3,   8'd4,   8'd44, 0);

    for (int n = 0; n < 40; n++) begin
      send(8'($urandom), 8'($urandom), 8'($urandom), 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    for (int w = 0; w < 30 && sb.size() > 0; w++) @(negedge clk);
    if (sb.size() > 0) begin
      n_vec++; n_bad++;
      $display("FAIL drain timeout pending %0d", sb.size());
    end
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
